// File: rtl/ip_pkt_pkg.sv
// Shared constants and state encoding for the IPv4 transmit/receive paths.
package ip_pkt_pkg;

    localparam int ETH_HDR_SIZE_BYTES = 14;
    localparam int IP_HDR_SIZE_BYTES  = 20;
    localparam int MIN_FRAME_BYTES    = 60;
    localparam int CSUM_WORDS         = IP_HDR_SIZE_BYTES / 2;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_TTL         = 8'h40;
    localparam logic [7:0]  IP_PROTO       = 8'hFD;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

    typedef enum logic [2:0] {
        IDLE,
        CSUM,
        SEND_ETH_HDR,
        SEND_IP_HDR,
        SEND_USER_DATA,
        SEND_PAD
    } tx_state_t;

    // Zero bytes needed to lift a short frame to the Ethernet minimum (FCS excluded).
    function automatic int pad_bytes(input int user_bytes);
        int p;
        p = MIN_FRAME_BYTES - ETH_HDR_SIZE_BYTES - IP_HDR_SIZE_BYTES - user_bytes;
        return (p > 0) ? p : 0;
    endfunction

endpackage

// File: rtl/counter_sync_reset.sv
// Up-counter with synchronous clear and enable; clear wins over enable.
module counter_sync_reset #(
    parameter int WIDTH = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ip_header_checksum.sv
// IPv4 header checksum: sums ten header words after start, folds and complements on the last.
module ip_header_checksum
    import ip_pkt_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        start,
    input  logic [15:0] word_in,
    output logic        done,
    output logic [15:0] checksum
);

    logic        active;
    logic [3:0]  idx;
    logic [19:0] acc;
    logic [19:0] sum;
    logic [16:0] fold1;
    logic [15:0] fold2;

    counter_sync_reset #(.WIDTH(4)) u_word_cnt (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clear  (start || done),
        .en     (active),
        .count  (idx)
    );

    assign done  = active && (idx == 4'(CSUM_WORDS - 1));
    assign sum   = acc + {4'b0, word_in};
    // Two end-around folds absorb every carry a 20-bit sum of ten words can hold.
    assign fold1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    assign fold2 = fold1[15:0] + {15'b0, fold1[16]};

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            active   <= 1'b0;
            acc      <= '0;
            checksum <= '0;
        end else if (start) begin
            active <= 1'b1;
            acc    <= '0;
        end else if (active) begin
            acc <= sum;
            if (done) begin
                active   <= 1'b0;
                checksum <= ~fold2;
            end
        end
    end

endmodule

// File: rtl/ip_packet_tx.sv
// Builds Ethernet II + IPv4 headers around one accelerator result and streams
// header, payload and zero padding to the MAC as 8-bit AXI-Stream (no FCS).
module ip_packet_tx
    import ip_pkt_pkg::*;
#(
    parameter int USER_DATA_BYTES = 1,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
    input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
    input  logic [31:0]                  DST_IP_ADDRESS,
    input  logic [47:0]                  DST_MAC_ADDRESS,
    input  logic                         FRAME_VALID,
    output logic                         FRAME_ACCEPT,
    output logic                         BUSY,
    output logic [7:0]                   MAC_DATA_IN,
    output logic                         MAC_DATA_VALID,
    input  logic                         MAC_DATA_READY,
    output logic                         MAC_DATA_LAST,
    output logic                         MAC_DATA_TUSER
);

    localparam int PAD_BYTES = pad_bytes(USER_DATA_BYTES);
    localparam logic [15:0] TOTAL_LEN = 16'(IP_HDR_SIZE_BYTES + USER_DATA_BYTES);
    localparam logic [COUNTER_WIDTH-1:0] ETH_LAST  = COUNTER_WIDTH'(ETH_HDR_SIZE_BYTES - 1);
    localparam logic [COUNTER_WIDTH-1:0] IP_LAST   = COUNTER_WIDTH'(IP_HDR_SIZE_BYTES - 1);
    localparam logic [COUNTER_WIDTH-1:0] USER_LAST = COUNTER_WIDTH'(USER_DATA_BYTES - 1);
    localparam logic [COUNTER_WIDTH-1:0] PAD_LAST  = COUNTER_WIDTH'((PAD_BYTES > 0) ? PAD_BYTES - 1 : 0);

    tx_state_t                    state_q, state_d;
    logic [USER_DATA_BYTES*8-1:0] data_r;
    logic [31:0]                  src_ip_r, dst_ip_r;
    logic [47:0]                  src_mac_r, dst_mac_r;
    logic [15:0]                  ident_q;
    logic [COUNTER_WIDTH-1:0]     byte_cnt;
    logic [COUNTER_WIDTH+2:0]     byte_shift;
    logic                         last_byte, xfer, csum_done, cnt_clear;
    logic [15:0]                  csum, csum_word;
    logic [111:0]                 eth_vec;
    logic [159:0]                 ip_base, ip_vec;

    assign FRAME_ACCEPT   = (state_q == IDLE) && FRAME_VALID;
    assign BUSY           = (state_q != IDLE);
    assign MAC_DATA_TUSER = 1'b0;
    assign xfer           = MAC_DATA_VALID && MAC_DATA_READY;

    // Header images with wire byte 0 in the low bits, so byte n is a right shift by 8n.
    assign eth_vec = {ETHERTYPE_IPV4[7:0], ETHERTYPE_IPV4[15:8], src_mac_r, dst_mac_r};
    assign ip_base = {dst_ip_r, src_ip_r, 16'h0000, IP_PROTO, IP_TTL,
                      IP_FLAGS_DF[7:0], IP_FLAGS_DF[15:8], ident_q[7:0], ident_q[15:8],
                      TOTAL_LEN[7:0], TOTAL_LEN[15:8], 8'h00, IP_VER_IHL};
    assign ip_vec  = ip_base | {64'd0, csum[7:0], csum[15:8], 80'd0};

    assign byte_shift = {byte_cnt, 3'b000};
    assign csum_word  = {8'(ip_base >> {byte_cnt, 4'b0000}), 8'(ip_base >> {byte_cnt, 4'b1000})};

    ip_header_checksum u_csum (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .start    (FRAME_ACCEPT),
        .word_in  (csum_word),
        .done     (csum_done),
        .checksum (csum)
    );

    // The counter ticks every CSUM cycle and per transferred byte in the SEND states.
    assign cnt_clear = (state_q == IDLE) || ((state_q == CSUM) && csum_done) || (xfer && last_byte);

    counter_sync_reset #(.WIDTH(COUNTER_WIDTH)) u_byte_cnt (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clear  (cnt_clear),
        .en     ((state_q == CSUM) || xfer),
        .count  (byte_cnt)
    );

    // NOTE: capture registers are reset too, so outputs never carry X after reset.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state_q   <= IDLE;
            ident_q   <= '0;
            data_r    <= '0;
            src_ip_r  <= '0;
            dst_ip_r  <= '0;
            src_mac_r <= '0;
            dst_mac_r <= '0;
        end else begin
            state_q <= state_d;
            if (FRAME_ACCEPT) begin
                data_r    <= DATA_FRAME;
                src_ip_r  <= ACCELERATOR_IP_ADDRESS;
                dst_ip_r  <= DST_IP_ADDRESS;
                src_mac_r <= ACCELERATOR_MAC_ADDRESS;
                dst_mac_r <= DST_MAC_ADDRESS;
            end
            if (xfer && MAC_DATA_LAST) begin
                ident_q <= ident_q + 16'd1;
            end
        end
    end

    // NOTE: every output of this block is defaulted first, which rules out inferred latches.
    always_comb begin
        state_d        = state_q;
        MAC_DATA_VALID = 1'b0;
        MAC_DATA_IN    = 8'h00;
        MAC_DATA_LAST  = 1'b0;
        last_byte      = 1'b0;
        case (state_q)
            IDLE: if (FRAME_VALID) state_d = CSUM;
            CSUM: if (csum_done) state_d = SEND_ETH_HDR;
            SEND_ETH_HDR: begin
                MAC_DATA_VALID = 1'b1;
                MAC_DATA_IN    = 8'(eth_vec >> byte_shift);
                last_byte      = (byte_cnt == ETH_LAST);
                if (MAC_DATA_READY && last_byte) state_d = SEND_IP_HDR;
            end
            SEND_IP_HDR: begin
                MAC_DATA_VALID = 1'b1;
                MAC_DATA_IN    = 8'(ip_vec >> byte_shift);
                last_byte      = (byte_cnt == IP_LAST);
                if (MAC_DATA_READY && last_byte) state_d = SEND_USER_DATA;
            end
            SEND_USER_DATA: begin
                MAC_DATA_VALID = 1'b1;
                MAC_DATA_IN    = 8'(data_r >> byte_shift);
                last_byte      = (byte_cnt == USER_LAST);
                MAC_DATA_LAST  = last_byte && (PAD_BYTES == 0);
                if (MAC_DATA_READY && last_byte) state_d = (PAD_BYTES > 0) ? SEND_PAD : IDLE;
            end
            SEND_PAD: begin
                MAC_DATA_VALID = 1'b1;
                last_byte      = (byte_cnt == PAD_LAST);
                MAC_DATA_LAST  = last_byte;
                if (MAC_DATA_READY && last_byte) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
